// File: rtl/cp0_exception_pkg.sv
// cp0_exception_pkg
// Shared definitions for the CP0 exception unit: CP0 register numbers,
// ExcCode values, Status/Cause bit positions, reset constants, and the
// exception priority selector used by the top level.
package cp0_exception_pkg;

    // CP0 register numbers
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // Status / Cause bit positions
    localparam int ST_IE   = 0;
    localparam int ST_EXL  = 1;
    localparam int ST_BEV  = 22;
    localparam int CA_BD   = 31;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;
    // BEV is hard-wired to 1; every other Status bit resets to 0.
    localparam logic [31:0] STATUS_RESET       = 32'h0040_0000;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    typedef struct packed {
        logic      take;          // some exception source is active
        exc_code_e code;          // ExcCode of the winning source
        logic      bad_from_pc;   // BadVAddr <= mem_pc (fetch address error)
        logic      bad_from_data; // BadVAddr <= bad_addr (load/store error)
    } exc_sel_t;

    // Fixed-priority pick among the exception sources. ERET is not an
    // exception and is resolved separately, below all of these.
    function automatic exc_sel_t prioritize(
        input logic int_p,
        input logic adel_if,
        input logic ri,
        input logic ov,
        input logic sys,
        input logic bp,
        input logic adel_ld,
        input logic ades
    );
        exc_sel_t s;
        s.take          = 1'b1;
        s.code          = EXC_INT;
        s.bad_from_pc   = 1'b0;
        s.bad_from_data = 1'b0;
        if (int_p)        s.code = EXC_INT;
        else if (adel_if) begin s.code = EXC_ADEL; s.bad_from_pc = 1'b1; end
        else if (ri)      s.code = EXC_RI;
        else if (ov)      s.code = EXC_OV;
        else if (sys)     s.code = EXC_SYS;
        else if (bp)      s.code = EXC_BP;
        else if (adel_ld) begin s.code = EXC_ADEL; s.bad_from_data = 1'b1; end
        else if (ades)    begin s.code = EXC_ADES; s.bad_from_data = 1'b1; end
        else              s.take = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/cp0_exception_timer.sv
// cp0_exception_timer
// Count/Compare timer. Count advances every second cycle (internal toggle)
// and wraps naturally. timer_int latches when Count==Compare and is only
// cleared by a write to Compare.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   we, waddr, wdata  MTC0 write port (already qualified by the caller)
//   count, compare    current register values
//   timer_int         latched timer interrupt
module cp0_exception_timer
    import cp0_exception_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    logic tick;
    logic wr_count;
    logic wr_compare;

    assign wr_count   = we && (waddr == CP0_COUNT);
    assign wr_compare = we && (waddr == CP0_COMPARE);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick      <= 1'b0;
            count     <= '0;
            compare   <= '0;
            timer_int <= 1'b0;
        end else begin
            tick <= ~tick;
            // A software write overrides the increment in the same cycle.
            if (wr_count)  count <= wdata;
            else if (tick) count <= count + 32'd1;
            // Writing Compare acknowledges the interrupt, even on a match cycle.
            if (wr_compare) begin
                compare   <= wdata;
                timer_int <= 1'b0;
            end else if (count == compare) begin
                timer_int <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_exception.sv
// cp0_exception
// CP0 exception unit at the MEM/WB boundary. Selects at most one exception
// (or an ERET) per cycle for the MEM-stage instruction, raises a
// combinational flush/redirect, and commits Status/Cause/EPC/BadVAddr at
// the clock edge. Also serves MFC0 reads and MTC0 writes.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   mem_valid, mem_pc, mem_in_delay_slot   MEM-stage instruction info
//   eret/syscall/break/ri/ov_flag, adel_if/adel_ld/ades_st   exception flags
//   bad_addr                       faulting data address
//   hw_int                         level-sensitive interrupt lines
//   cp0_we/waddr/wdata, cp0_raddr  MTC0 write / MFC0 read port
//   cp0_rdata                      combinational MFC0 data (pre-edge values)
//   flush, redirect_pc             pipeline squash and next-fetch PC
//   epc_out, status_out, cause_out current register values
module cp0_exception
    import cp0_exception_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_in_delay_slot,
    input  logic        eret_flag,
    input  logic        syscall_flag,
    input  logic        break_flag,
    input  logic        ri_flag,
    input  logic        ov_flag,
    input  logic        adel_if,
    input  logic        adel_ld,
    input  logic        ades_st,
    input  logic [31:0] bad_addr,
    input  logic [5:0]  hw_int,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [4:0]  cp0_raddr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] epc_out,
    output logic [31:0] status_out,
    output logic [31:0] cause_out
);

    // Only the architecturally writable fields are stored.
    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    exc_code_e   cause_exc;
    logic [31:0] epc;
    logic [31:0] badvaddr;

    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_int;

    logic        int_pending;
    exc_sel_t    sel;
    logic        exc_take;
    logic        eret_take;
    logic        mtc0;

    assign int_pending = status_ie && !status_exl &&
                         (|({cause_ip_hw, cause_ip_sw} & status_im));

    always_comb begin
        sel = prioritize(int_pending, adel_if, ri_flag, ov_flag,
                         syscall_flag, break_flag, adel_ld, ades_st);
    end

    assign exc_take  = mem_valid && sel.take;
    assign eret_take = mem_valid && eret_flag && !sel.take;
    // An exception in the same cycle drops the MTC0 entirely.
    assign mtc0      = cp0_we && !exc_take;

    always_comb begin
        flush       = 1'b0;
        redirect_pc = '0;
        if (!rst) begin
            flush = exc_take || eret_take;
            if (exc_take)       redirect_pc = EXC_VECTOR;
            else if (eret_take) redirect_pc = epc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_im   <= '0;
            status_exl  <= 1'b0;
            status_ie   <= 1'b0;
            cause_bd    <= 1'b0;
            cause_ip_hw <= '0;
            cause_ip_sw <= '0;
            cause_exc   <= EXC_INT;
            epc         <= '0;
            badvaddr    <= '0;
        end else begin
            // Hardware interrupt lines are resampled every cycle; IP7 is
            // shared between the timer and hw_int[5].
            cause_ip_hw <= {timer_int | hw_int[5], hw_int[4:0]};

            if (mtc0 && cp0_waddr == CP0_STATUS) begin
                status_im  <= cp0_wdata[15:8];
                status_exl <= cp0_wdata[ST_EXL];
                status_ie  <= cp0_wdata[ST_IE];
            end
            if (mtc0 && cp0_waddr == CP0_CAUSE) cause_ip_sw <= cp0_wdata[9:8];
            if (mtc0 && cp0_waddr == CP0_EPC)   epc         <= cp0_wdata;

            if (exc_take) begin
                cause_exc  <= sel.code;
                status_exl <= 1'b1;
                // Nested exception while EXL=1 keeps the original return point.
                if (!status_exl) begin
                    epc      <= mem_in_delay_slot ? mem_pc - 32'd4 : mem_pc;
                    cause_bd <= mem_in_delay_slot;
                end
                if (sel.bad_from_pc)   badvaddr <= mem_pc;
                if (sel.bad_from_data) badvaddr <= bad_addr;
            end else if (eret_take) begin
                status_exl <= 1'b0;
            end
        end
    end

    cp0_exception_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .we        (mtc0),
        .waddr     (cp0_waddr),
        .wdata     (cp0_wdata),
        .count     (count),
        .compare   (compare),
        .timer_int (timer_int)
    );

    assign status_out = STATUS_RESET | {16'b0, status_im, 6'b0, status_exl, status_ie};
    assign cause_out  = {cause_bd, 15'b0, cause_ip_hw, cause_ip_sw, 1'b0, cause_exc, 2'b0};
    assign epc_out    = epc;

    always_comb begin
        cp0_rdata = '0;
        case (cp0_raddr)
            CP0_BADVADDR: cp0_rdata = badvaddr;
            CP0_COUNT:    cp0_rdata = count;
            CP0_COMPARE:  cp0_rdata = compare;
            CP0_STATUS:   cp0_rdata = status_out;
            CP0_CAUSE:    cp0_rdata = cause_out;
            CP0_EPC:      cp0_rdata = epc;
            default:      cp0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exception.sv
// tb_cp0_exception
// Directed scenarios followed by a randomized run, all checked against an
// architectural model holding whole 32-bit CP0 register images.
module tb_cp0_exception;

    localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_in_delay_slot;
    logic [31:0] mem_pc, bad_addr, cp0_wdata;
    logic        eret_flag, syscall_flag, break_flag, ri_flag, ov_flag;
    logic        adel_if, adel_ld, ades_st;
    logic [5:0]  hw_int;
    logic        cp0_we;
    logic [4:0]  cp0_waddr, cp0_raddr;
    logic [31:0] cp0_rdata, redirect_pc, epc_out, status_out, cause_out;
    logic        flush;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cp0_exception dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_pc(mem_pc),
        .mem_in_delay_slot(mem_in_delay_slot), .eret_flag(eret_flag),
        .syscall_flag(syscall_flag), .break_flag(break_flag), .ri_flag(ri_flag),
        .ov_flag(ov_flag), .adel_if(adel_if), .adel_ld(adel_ld), .ades_st(ades_st),
        .bad_addr(bad_addr), .hw_int(hw_int), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr),
        .cp0_raddr(cp0_raddr), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
        .flush(flush), .redirect_pc(redirect_pc), .epc_out(epc_out),
        .status_out(status_out), .cause_out(cause_out)
    );

    // Architectural model: full register images
    logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare;
    logic        m_tick, m_timer;

    function automatic logic [4:0] code_of(int i);
        case (i)
            0: return 5'd0;  1: return 5'd4;  2: return 5'd10; 3: return 5'd12;
            4: return 5'd8;  5: return 5'd9;  6: return 5'd4;  default: return 5'd5;
        endcase
    endfunction

    function automatic bit m_int();
        return m_status[0] && !m_status[1] && (|(m_cause[15:8] & m_status[15:8]));
    endfunction

    // Index of the winning event in priority order: 0..7 exceptions, 8 ERET, -1 none
    function automatic int pick();
        bit fl[9];
        if (!mem_valid) return -1;
        fl = '{m_int(), adel_if, ri_flag, ov_flag, syscall_flag, break_flag,
               adel_ld, ades_st, eret_flag};
        for (int i = 0; i < 9; i++) if (fl[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] m_read(logic [4:0] a);
        case (a)
            5'd8:  return m_badv;
            5'd9:  return m_count;
            5'd11: return m_compare;
            5'd12: return m_status;
            5'd13: return m_cause;
            5'd14: return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        int idx;
        logic [31:0] n_status, n_cause, n_epc, n_badv, n_count, n_compare;
        logic n_timer;
        bit is_exc, wr_cmp, wr_cnt;
        if (rst) begin
            m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_badv = 0;
            m_count = 0; m_compare = 0; m_tick = 0; m_timer = 0;
            return;
        end
        idx = pick();
        is_exc = (idx >= 0 && idx < 8);
        n_status = m_status; n_cause = m_cause; n_epc = m_epc; n_badv = m_badv;
        n_compare = m_compare;
        wr_cmp = !is_exc && cp0_we && cp0_waddr == 5'd11;
        wr_cnt = !is_exc && cp0_we && cp0_waddr == 5'd9;
        if (is_exc) begin
            n_cause[6:2] = code_of(idx);
            n_status[1] = 1'b1;
            if (!m_status[1]) begin
                n_epc = mem_in_delay_slot ? mem_pc - 4 : mem_pc;
                n_cause[31] = mem_in_delay_slot;
            end
            if (idx == 1) n_badv = mem_pc;
            else if (idx == 6 || idx == 7) n_badv = bad_addr;
        end else if (cp0_we) begin
            case (cp0_waddr)
                5'd12: n_status = (m_status & ~32'h0000_FF03) | (cp0_wdata & 32'h0000_FF03);
                5'd13: n_cause  = (m_cause & ~32'h0000_0300) | (cp0_wdata & 32'h0000_0300);
                5'd14: n_epc    = cp0_wdata;
                5'd11: n_compare = cp0_wdata;
                default: ;
            endcase
        end
        if (idx == 8) n_status[1] = 1'b0;
        n_cause[15:10] = {m_timer | hw_int[5], hw_int[4:0]};
        n_timer = wr_cmp ? 1'b0 : ((m_count == m_compare) ? 1'b1 : m_timer);
        n_count = wr_cnt ? cp0_wdata : (m_tick ? m_count + 1 : m_count);
        m_tick = ~m_tick;
        m_status = n_status; m_cause = n_cause; m_epc = n_epc; m_badv = n_badv;
        m_count = n_count; m_compare = n_compare; m_timer = n_timer;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int idx;
        logic exp_flush;
        idx = pick();
        exp_flush = !rst && idx >= 0;
        chk("flush", 32'(flush), 32'(exp_flush));
        if (rst) chk("redirect_rst", redirect_pc, 32'h0);
        else if (exp_flush) chk("redirect", redirect_pc, (idx == 8) ? m_epc : EXC_VEC);
        chk("status", status_out, m_status);
        chk("cause", cause_out, m_cause);
        chk("epc", epc_out, m_epc);
        chk("rdata", cp0_rdata, m_read(cp0_raddr));
    endtask

    task automatic half();     @(negedge clk); check_all(); endtask
    task automatic edge_clk(); @(posedge clk); model_edge(); #1; endtask
    task automatic step();     half(); edge_clk(); endtask

    task automatic clear_in();
        mem_valid = 0; mem_pc = 32'h8000_0000; mem_in_delay_slot = 0;
        eret_flag = 0; syscall_flag = 0; break_flag = 0; ri_flag = 0; ov_flag = 0;
        adel_if = 0; adel_ld = 0; ades_st = 0; bad_addr = 0; hw_int = 0;
        cp0_we = 0; cp0_waddr = 0; cp0_wdata = 0; cp0_raddr = 5'd12;
    endtask

    task automatic mtc0(logic [4:0] a, logic [31:0] d);
        clear_in(); cp0_we = 1; cp0_waddr = a; cp0_wdata = d; step();
    endtask

    task automatic eret(logic [31:0] exp_target);
        clear_in(); mem_valid = 1; eret_flag = 1;
        half(); chk("eret_redirect", redirect_pc, exp_target); edge_clk();
    endtask

    int addrs[8] = '{8, 9, 11, 12, 13, 14, 3, 20};

    initial begin
        int waited;
        logic [31:0] int_pc;
        m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_badv = 0;
        m_count = 0; m_compare = 0; m_tick = 0; m_timer = 0;

        // Reset, with an exception request present that must be ignored
        clear_in(); rst = 1; mem_valid = 1; syscall_flag = 1;
        edge_clk();
        half(); chk("rst_flush", 32'(flush), 32'h0); chk("rst_redirect", redirect_pc, 32'h0);
        edge_clk();
        rst = 0; clear_in();
        half();
        chk("rst_status", status_out, 32'h0040_0000);
        chk("rst_cause", cause_out, 32'h0);
        chk("rst_epc", epc_out, 32'h0);
        edge_clk();

        // Syscall outside a delay slot
        clear_in(); mem_valid = 1; syscall_flag = 1; mem_pc = 32'hBFC0_0100;
        half(); chk("sys_flush", 32'(flush), 32'h1); chk("sys_redirect", redirect_pc, EXC_VEC);
        edge_clk();
        clear_in(); half();
        chk("sys_epc", epc_out, 32'hBFC0_0100);
        chk("sys_code", 32'(cause_out[6:2]), 32'd8);
        chk("sys_exl", 32'(status_out[1]), 32'h1);
        edge_clk();
        eret(32'hBFC0_0100);

        // Ov beats Sys, delay slot adjusts EPC and sets BD
        clear_in(); mem_valid = 1; ov_flag = 1; syscall_flag = 1;
        mem_in_delay_slot = 1; mem_pc = 32'h8000_0010;
        step();
        clear_in(); half();
        chk("ov_code", 32'(cause_out[6:2]), 32'd12);
        chk("ov_epc", epc_out, 32'h8000_000C);
        chk("ov_bd", 32'(cause_out[31]), 32'h1);
        edge_clk();
        eret(32'h8000_000C);

        // Hardware interrupt 0, then ERET back to it
        clear_in(); cp0_we = 1; cp0_waddr = 5'd12; cp0_wdata = 32'h0000_0401; hw_int = 6'b000001;
        step();
        clear_in(); hw_int = 6'b000001; mem_valid = 1; mem_pc = 32'h8000_0200; int_pc = mem_pc;
        half(); chk("int_flush", 32'(flush), 32'h1); chk("int_redirect", redirect_pc, EXC_VEC);
        edge_clk();
        clear_in(); half();
        chk("int_code", 32'(cause_out[6:2]), 32'd0);
        chk("int_epc", epc_out, int_pc);
        edge_clk();
        eret(int_pc);
        clear_in(); half(); chk("eret_exl", 32'(status_out[1]), 32'h0); edge_clk();

        // Timer: Count=0, Compare=10, wait for IP7, then clear via Compare
        mtc0(5'd12, 32'h0);
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'd10);
        clear_in(); cp0_raddr = 5'd9; step(); step();
        half(); chk("timer_cleared", 32'(cause_out[15]), 32'h0); edge_clk();
        waited = 0;
        while (cause_out[15] !== 1'b1 && waited < 60) begin step(); waited++; end
        chk("timer_fires", 32'(cause_out[15]), 32'h1);
        mtc0(5'd11, 32'd1000);
        clear_in(); step();
        half(); chk("timer_ack", 32'(cause_out[15]), 32'h0); edge_clk();

        // AdES with a simultaneous MTC0 to EPC that must be dropped
        clear_in(); mem_valid = 1; ades_st = 1; bad_addr = 32'h0000_0003;
        mem_pc = 32'h8000_0040; cp0_we = 1; cp0_waddr = 5'd14; cp0_wdata = 32'hDEAD_BEEF;
        step();
        clear_in(); cp0_raddr = 5'd8; half();
        chk("ades_badv", cp0_rdata, 32'h0000_0003);
        chk("ades_code", 32'(cause_out[6:2]), 32'd5);
        chk("ades_epc", epc_out, 32'h8000_0040);
        edge_clk();

        // Randomized traffic, including occasional reset mid-stream
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            mem_valid = ($urandom_range(0, 3) != 0);
            mem_pc = $urandom & 32'hFFFF_FFFC;
            mem_in_delay_slot = $urandom_range(0, 1);
            eret_flag = ($urandom_range(0, 7) == 0);
            syscall_flag = ($urandom_range(0, 9) == 0);
            break_flag = ($urandom_range(0, 9) == 0);
            ri_flag = ($urandom_range(0, 11) == 0);
            ov_flag = ($urandom_range(0, 11) == 0);
            adel_if = ($urandom_range(0, 15) == 0);
            adel_ld = ($urandom_range(0, 11) == 0);
            ades_st = ($urandom_range(0, 11) == 0);
            bad_addr = $urandom;
            hw_int = 6'($urandom & $urandom & $urandom);
            cp0_we = ($urandom_range(0, 3) == 0);
            cp0_waddr = 5'(addrs[$urandom_range(0, 7)]);
            cp0_wdata = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 40);
            cp0_raddr = 5'($urandom_range(0, 15));
            step();
        end
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
